// File: rtl/tap_mux_pkg.sv
// Shared types and helpers for the tap_mux_seq word selector / tap sequencer.
//   state_e   : sequencer FSM states
//   clamp_len : limits a requested scan length to the number of input words
package tap_mux_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Saturate a requested scan length at n words.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned n);
    return (len > n) ? n : len;
  endfunction

endpackage

// File: rtl/tap_mux_word_sel.sv
// Combinational N:1 word select from a flat bus; out-of-range index yields 0.
//   data_in : N*WIDTH flat bus, word k = data_in[k*WIDTH +: WIDTH]
//   idx     : word index
//   word_c  : selected word (combinational)
module tap_mux_word_sel #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 16,
  parameter int unsigned LOGN  = 4
) (
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [LOGN-1:0]    idx,
  output logic [WIDTH-1:0]   word_c
);

  // Compare against every legal index; no match leaves the zero default.
  always_comb begin
    word_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == LOGN'(k)) begin
        word_c = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/tap_mux_seq.sv
// Registered N:1 word selector with valid/ready output and a built-in tap sequencer.
// DIRECT mode returns one word per sel request; SCAN mode streams words 0..len-1.
// Optional feature macro: TAP_MUX_SEQ_REVERSE_EN adds the dir input (1 = descending scan).
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   data_in         : flat N*WIDTH input bus
//   sel, sel_valid  : DIRECT request; sel_ready is combinational (accept = valid & ready)
//   start, len      : begin a SCAN of len words (clamped to N), sampled only in IDLE
//   data_out, tap_idx, last, out_valid : registered output beat; out_ready accepts it
//   busy            : high while scanning
//   done            : one-cycle pulse when a scan completes
//   dir             : (TAP_MUX_SEQ_REVERSE_EN only) scan direction, captured on start
module tap_mux_seq
  import tap_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 16,
  parameter int unsigned LOGN  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [LOGN-1:0]    sel,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic               start,
  input  logic [LOGN:0]      len,
  output logic [WIDTH-1:0]   data_out,
  output logic [LOGN-1:0]    tap_idx,
  output logic               last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
`ifdef TAP_MUX_SEQ_REVERSE_EN
  ,
  input  logic               dir
`endif
);

  localparam int unsigned LW = LOGN + 1;

  state_e            state_q, state_d;
  logic [LOGN-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]     len_q, len_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [LOGN-1:0]   idx_q, idx_d;
  logic              last_q, last_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef TAP_MUX_SEQ_REVERSE_EN
  logic              dir_q, dir_d;
`endif

  logic              load_c;
  logic              sel_ready_c;
  logic [LW-1:0]     len_clamped_c;
  logic [LW-1:0]     len_m1_c;
  logic [LOGN-1:0]   first_idx_c;
  logic              scan_last_c;
  logic [LOGN-1:0]   rd_idx_c;
  logic [WIDTH-1:0]  word_c;

  // One shared word select; the FSM steers its index.
  tap_mux_word_sel #(
    .WIDTH (WIDTH),
    .N     (N),
    .LOGN  (LOGN)
  ) u_word_sel (
    .data_in (data_in),
    .idx     (rd_idx_c),
    .word_c  (word_c)
  );

  // Scan bookkeeping: clamped length, starting index, final-beat detect.
  always_comb begin
    len_clamped_c = LW'(clamp_len(32'(len), N));
    len_m1_c      = len_q - LW'(1);
`ifdef TAP_MUX_SEQ_REVERSE_EN
    first_idx_c   = dir ? LOGN'(len_clamped_c - LW'(1)) : '0;
    scan_last_c   = dir_q ? (cnt_q == '0) : (cnt_q == LOGN'(len_m1_c));
`else
    first_idx_c   = '0;
    scan_last_c   = (cnt_q == LOGN'(len_m1_c));
`endif
  end

  // Next-state and output-slot logic.
  always_comb begin
    load_c      = !out_valid_q || out_ready;
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    data_d      = data_q;
    idx_d       = idx_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    sel_ready_c = 1'b0;
    rd_idx_c    = sel;
`ifdef TAP_MUX_SEQ_REVERSE_EN
    dir_d       = dir_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // start has priority over a simultaneous DIRECT request.
        sel_ready_c = load_c && !start;
        if (start) begin
          if (len_clamped_c != '0) begin
            state_d = ST_SCAN;
            len_d   = len_clamped_c;
            cnt_d   = first_idx_c;
`ifdef TAP_MUX_SEQ_REVERSE_EN
            dir_d   = dir;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
        if (load_c) begin
          if (sel_valid && sel_ready_c) begin
            out_valid_d = 1'b1;
            data_d      = word_c;
            idx_d       = sel;
            last_d      = 1'b1;
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end

      ST_SCAN: begin
        rd_idx_c = cnt_q;
        if (load_c) begin
          out_valid_d = 1'b1;
          data_d      = word_c;
          idx_d       = cnt_q;
          last_d      = scan_last_c;
          if (scan_last_c) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef TAP_MUX_SEQ_REVERSE_EN
            cnt_d = dir_q ? (cnt_q - LOGN'(1)) : (cnt_q + LOGN'(1));
`else
            cnt_d = cnt_q + LOGN'(1);
`endif
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SCAN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef TAP_MUX_SEQ_REVERSE_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef TAP_MUX_SEQ_REVERSE_EN
      dir_q       <= dir_d;
`endif
    end
  end

  assign sel_ready = sel_ready_c;
  assign data_out  = data_q;
  assign tap_idx   = idx_q;
  assign last      = last_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
